// File: rtl/video_shifter.sv
// video_shifter: serial dot generator for text, hi-res and lo-res video.
// Builds the dot stream from bytes loaded on the timing PAL strobe and derives
// the text flash phase from a frame counter.
// Optional feature: define VIDEO_SHIFTER_LORES_EN to include the lo-res nibble
// ring. Without it, gr=1/hires=0 bytes go through the hi-res shifter with no
// half-dot delay.
module video_shifter (
    input  logic       clk_14M,
    input  logic       reset,
    input  logic       ldps_n,
    input  logic       vid7m,
    input  logic       eighty_vid_n,
    input  logic       gr,
    input  logic       hires,
    input  logic       h0,
    input  logic       segb,
    input  logic [7:0] vid_data,
    input  logic       text_inv,
    input  logic       text_flash,
    input  logic       vsync,
    output logic       vid_out,
    output logic       flash
);

    logic       sh_en;
    logic       load;
    logic [6:0] shift_q, shift_d;
    logic       delay_q;
    logic       gr_q, hires_q, hd_q, inv_q, tflash_q;
    logic [3:0] frame_q, frame_d;
    logic       flash_q, flash_d;
    logic       vid_q, vid_d;
    logic       lores_sel;
    logic       lores_dot;

    // 80-column and double modes shift on every master clock.
    assign sh_en = ~eighty_vid_n | vid7m;
    assign load  = ~ldps_n;

    // Dot shifter next state: load beats shift; zeros fill from the top so an
    // over-run byte goes blank instead of repeating.
    always_comb begin
        shift_d = shift_q;
        if (load) begin
            shift_d = vid_data[6:0];
        end else if (sh_en) begin
            shift_d = {1'b0, shift_q[6:1]};
        end
    end

    // Shifter, half-dot delay tap and per-byte mode latches.
    always_ff @(posedge clk_14M) begin
        if (reset) begin
            shift_q  <= '0;
            delay_q  <= 1'b0;
            gr_q     <= 1'b0;
            hires_q  <= 1'b0;
            hd_q     <= 1'b0;
            inv_q    <= 1'b0;
            tflash_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            // Runs every cycle so the last dot of one byte carries into the next.
            delay_q <= shift_q[0];
            if (load) begin
                gr_q     <= gr;
                hires_q  <= hires;
                hd_q     <= vid_data[7];
                inv_q    <= text_inv;
                tflash_q <= text_flash;
            end
        end
    end

`ifdef VIDEO_SHIFTER_LORES_EN
    logic [3:0] ring_q, ring_d;
    logic [3:0] nib;

    // Lo-res ring next state: odd columns start two places further round; the
    // ring free-runs at the master clock independent of the shift enable.
    always_comb begin
        nib = segb ? vid_data[7:4] : vid_data[3:0];
        if (load) begin
            ring_d = h0 ? {nib[1:0], nib[3:2]} : nib;
        end else begin
            ring_d = {ring_q[0], ring_q[3:1]};
        end
    end

    // Lo-res ring register.
    always_ff @(posedge clk_14M) begin
        if (reset) begin
            ring_q <= '0;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign lores_sel = gr_q & ~hires_q;
    assign lores_dot = ring_q[0];
`else
    // Column parity and nibble select only matter to the lo-res ring.
    logic unused_lores;
    assign unused_lores = h0 ^ segb;
    assign lores_sel    = 1'b0;
    assign lores_dot    = 1'b0;
`endif

    // Frame counter next state: flash phase flips each time the counter wraps.
    always_comb begin
        frame_d = frame_q;
        flash_d = flash_q;
        if (vsync) begin
            frame_d = frame_q + 4'd1;
            if (frame_q == 4'hF) begin
                flash_d = ~flash_q;
            end
        end
    end

    // Output dot selection by the mode latched with the current byte.
    always_comb begin
        vid_d = shift_q[0];
        if (!gr_q) begin
            vid_d = shift_q[0] ^ (inv_q | (tflash_q & flash_q));
        end else if (lores_sel) begin
            vid_d = lores_dot;
        end else if (hires_q && hd_q) begin
            vid_d = delay_q;
        end
    end

    // Registered dot output and flash state.
    always_ff @(posedge clk_14M) begin
        if (reset) begin
            vid_q   <= 1'b0;
            frame_q <= '0;
            flash_q <= 1'b0;
        end else begin
            vid_q   <= vid_d;
            frame_q <= frame_d;
            flash_q <= flash_d;
        end
    end

    assign vid_out = vid_q;
    assign flash   = flash_q;

endmodule

// File: tb/tb_video_shifter.sv
// tb_video_shifter: directed bench for video_shifter with a per-cycle
// behavioural model plus hand-computed dot sequences.
`timescale 1ns/1ps
module tb_video_shifter;

    logic       clk_14M = 1'b0;
    logic       reset;
    logic       ldps_n;
    logic       vid7m;
    logic       eighty_vid_n;
    logic       gr;
    logic       hires;
    logic       h0;
    logic       segb;
    logic [7:0] vid_data;
    logic       text_inv;
    logic       text_flash;
    logic       vsync;
    logic       vid_out;
    logic       flash;

    always #35 clk_14M = ~clk_14M;

    video_shifter dut (
        .clk_14M      (clk_14M),
        .reset        (reset),
        .ldps_n       (ldps_n),
        .vid7m        (vid7m),
        .eighty_vid_n (eighty_vid_n),
        .gr           (gr),
        .hires        (hires),
        .h0           (h0),
        .segb         (segb),
        .vid_data     (vid_data),
        .text_inv     (text_inv),
        .text_flash   (text_flash),
        .vsync        (vsync),
        .vid_out      (vid_out),
        .flash        (flash)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the loaded byte, how many shifts have consumed it and how many
    // cycles have elapsed since the load; dots are read out by index.
    logic [7:0] m_byte  = '0;
    int         m_nsh   = 7;
    int         m_k     = 0;
    int         m_vs    = 0;
    logic       m_gr = 0, m_hires = 0, m_h0 = 0, m_segb = 0;
    logic       m_inv = 0, m_tf = 0, m_hd = 0, m_prev = 0;
    logic       m_ok    = 0;
    logic       m_dotv, m_lores, m_fl;
    logic [3:0] m_nib;
    logic       exp_vid = 0, exp_flash = 0;

    function automatic logic m_dot();
        return (m_nsh < 7) ? m_byte[m_nsh] : 1'b0;
    endfunction

    initial forever begin : model
        @(posedge clk_14M);
        m_dotv  = m_dot();
        m_fl    = ((m_vs / 16) % 2) == 1;
        m_lores = 1'b0;
`ifdef VIDEO_SHIFTER_LORES_EN
        m_lores = m_gr && !m_hires;
`endif
        m_nib = m_segb ? m_byte[7:4] : m_byte[3:0];
        if (!m_gr)                exp_vid = m_dotv ^ (m_inv | (m_tf & m_fl));
        else if (m_lores)         exp_vid = m_nib[(m_k + (m_h0 ? 2 : 0)) % 4];
        else if (m_hires && m_hd) exp_vid = m_prev;
        else                      exp_vid = m_dotv;
        if (reset) begin
            m_byte = '0; m_nsh = 7; m_k = 0; m_vs = 0; m_prev = 0;
            m_gr = 0; m_hires = 0; m_h0 = 0; m_segb = 0;
            m_inv = 0; m_tf = 0; m_hd = 0;
            exp_vid = 1'b0;
            m_ok = 1'b1;
        end else begin
            m_prev = m_dotv;
            if (vsync) m_vs++;
            if (!ldps_n) begin
                m_byte = vid_data; m_nsh = 0; m_k = 0;
                m_gr = gr; m_hires = hires; m_h0 = h0; m_segb = segb;
                m_inv = text_inv; m_tf = text_flash; m_hd = vid_data[7];
            end else begin
                if ((!eighty_vid_n || vid7m) && m_nsh < 7) m_nsh++;
                m_k = (m_k + 1) % 4;
            end
        end
        exp_flash = ((m_vs / 16) % 2) == 1;
    end

    initial forever begin : compare
        @(negedge clk_14M);
        if (m_ok) begin
            check("model vid_out", vid_out, exp_vid);
            check("model flash", flash, exp_flash);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input int n);
        @(negedge clk_14M);
        reset = 1'b1; ldps_n = 1'b1; vid7m = 1'b0; vsync = 1'b0;
        repeat (n) @(negedge clk_14M);
        reset = 1'b0;
    endtask

    // Loads d at the first edge (and d2 at edge ld2_at), then compares the
    // output seen after edges 1..16 with exp (MSB = first dot).
    task automatic run_seq(input string name, input logic [7:0] d, input logic [7:0] d2,
                           input int ld2_at, input bit v7_alt, input logic [15:0] exp);
        logic [17:0] obs;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_14M);
            obs[i]   = vid_out;
            ldps_n   = !(i == 0 || i == ld2_at);
            vid_data = (i == 0) ? d : d2;
            vid7m    = v7_alt ? (i % 2 == 0) : 1'b0;
        end
        ldps_n = 1'b1;
        for (int j = 0; j < 16; j++) check(name, obs[2 + j], exp[15 - j]);
    endtask

    task automatic set_mode(input logic g, input logic hr, input logic e80n,
                            input logic inv, input logic tf);
        gr = g; hires = hr; eighty_vid_n = e80n; text_inv = inv; text_flash = tf;
        h0 = 1'b0; segb = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge clk_14M); vsync = 1'b1;
        @(negedge clk_14M); vsync = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ldps_n = 1'b1; vid7m = 1'b0; eighty_vid_n = 1'b1;
        gr = 1'b0; hires = 1'b0; h0 = 1'b0; segb = 1'b0; vid_data = '0;
        text_inv = 1'b0; text_flash = 1'b0; vsync = 1'b0;
        repeat (3) @(negedge clk_14M);
        reset = 1'b0;
        check("reset vid_out", vid_out, 1'b0);
        check("reset flash", flash, 1'b0);

        // 40-column text: each dot lasts two cycles, blank after seven.
        do_reset(2); set_mode(0, 0, 1, 0, 0);
        run_seq("text40 0x55", 8'h55, 8'h00, -1, 1'b1, 16'hCCCC);

        // 80-column: 0x7F then 0x00 back to back.
        do_reset(2); set_mode(0, 0, 0, 0, 0);
        run_seq("text80 7F/00", 8'h7F, 8'h00, 7, 1'b0, 16'hFE00);

        // Inverse text: blank tail also inverts.
        do_reset(2); set_mode(0, 0, 0, 1, 0);
        run_seq("inverse 0x0F", 8'h0F, 8'h0F, -1, 1'b0, 16'h0FFF);

        // Hi-res half-dot delay.
        do_reset(2); set_mode(1, 1, 0, 0, 0);
        run_seq("hires 0x01", 8'h00, 8'h01, 7, 1'b0, 16'h0100);
        do_reset(2); set_mode(1, 1, 0, 0, 0);
        run_seq("hires 0x81", 8'h00, 8'h81, 7, 1'b0, 16'h0080);

`ifdef VIDEO_SHIFTER_LORES_EN
        do_reset(2); set_mode(1, 0, 0, 0, 0); segb = 1'b1;
        run_seq("lores A5 h0=0", 8'hA5, 8'h00, -1, 1'b0, 16'h5555);
        // 1010 is unchanged by a two-place rotation, so h0 leaves the phase alone.
        do_reset(2); set_mode(1, 0, 0, 0, 0); segb = 1'b1; h0 = 1'b1;
        run_seq("lores A5 h0=1", 8'hA5, 8'h00, -1, 1'b0, 16'h5555);
        do_reset(2); set_mode(1, 0, 0, 0, 0);
        run_seq("lores 31 h0=0", 8'h31, 8'h00, -1, 1'b0, 16'h8888);
        do_reset(2); set_mode(1, 0, 0, 0, 0); h0 = 1'b1;
        run_seq("lores 31 h0=1", 8'h31, 8'h00, -1, 1'b0, 16'h2222);
`else
        // Without the ring, lo-res bytes use the plain shifter, bit 7 ignored.
        do_reset(2); set_mode(1, 0, 0, 0, 0);
        run_seq("lores-off A5", 8'hA5, 8'h00, -1, 1'b0, 16'hA400);
`endif

        // Reset in the middle of a byte aborts it.
        do_reset(2); set_mode(0, 0, 0, 0, 0);
        @(negedge clk_14M); ldps_n = 1'b0; vid_data = 8'h7F;
        @(negedge clk_14M); ldps_n = 1'b1;
        @(negedge clk_14M);
        check("midbyte before reset", vid_out, 1'b1);
        reset = 1'b1;
        @(negedge clk_14M); reset = 1'b0;
        check("midbyte at reset", vid_out, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_14M);
            check("midbyte after reset", vid_out, 1'b0);
        end

        // Flash: 16 frames to flip, reset clears, vsync during reset ignored.
        do_reset(2); set_mode(0, 0, 0, 0, 1);
        @(negedge clk_14M); ldps_n = 1'b0; vid_data = 8'h00;
        @(negedge clk_14M); ldps_n = 1'b1;
        for (int p = 0; p < 16; p++) begin
            if (p == 15) check("flash before 16th", flash, 1'b0);
            pulse_vsync();
        end
        check("flash after 16", flash, 1'b1);
        @(negedge clk_14M);
        check("flash text dot", vid_out, 1'b1);
        for (int p = 0; p < 8; p++) pulse_vsync();
        @(negedge clk_14M); reset = 1'b1; vsync = 1'b1;
        @(negedge clk_14M); reset = 1'b0; vsync = 1'b0;
        check("flash reset", flash, 1'b0);
        check("flash reset dot", vid_out, 1'b0);
        for (int p = 0; p < 15; p++) pulse_vsync();
        check("flash 15 after reset", flash, 1'b0);
        pulse_vsync();
        check("flash 16 after reset", flash, 1'b1);

        repeat (2) @(negedge clk_14M);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
